// File: rtl/tone_gen.sv
// Square-wave tone generator: plays one note of a given half-period and length
// in milliseconds, optionally followed by a silent gap, with a start/busy/done handshake.
module tone_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 18,
  parameter int DUR_W  = 16,
  parameter int GAP_MS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] half_period,
  input  logic [DUR_W-1:0] dur_ms,
  output logic             tone,
  output logic             busy,
  output logic             done
);

  localparam int MS_DIV = CLK_HZ / 1000;
  localparam int PC_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(MS_DIV - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] hp_q;
  logic [CNT_W-1:0] hc;
  logic [DUR_W-1:0] dur_q;
  logic [DUR_W-1:0] mc;
  logic [PC_W-1:0]  pc;
  logic             ms_tick;
  logic             play_end;
  logic             gap_end;

  // Phases end on the last prescaler cycle of the last millisecond, so mc never
  // has to hold dur_ms itself and the maximum duration cannot wrap.
  assign ms_tick  = (pc == PC_LAST);
  assign play_end = ms_tick && (mc == dur_q - DUR_W'(1));
  assign gap_end  = ms_tick && (mc == GAP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      hp_q  <= '0;
      dur_q <= '0;
      hc    <= '0;
      mc    <= '0;
      pc    <= '0;
      tone  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            hp_q  <= half_period;
            dur_q <= dur_ms;
            hc    <= '0;
            pc    <= '0;
            mc    <= '0;
            tone  <= 1'b0;
            if (dur_ms != '0) begin
              state <= S_PLAY;
              busy  <= 1'b1;
            end else if (GAP_MS != 0) begin
              state <= S_GAP;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end

        S_PLAY: begin
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            tone  <= 1'b0;
            hc    <= '0;
            pc    <= '0;
            mc    <= '0;
          end else begin
            if (hp_q != '0) begin
              if (hc == hp_q - CNT_W'(1)) begin
                hc   <= '0;
                tone <= ~tone;
              end else begin
                hc <= hc + CNT_W'(1);
              end
            end
            if (ms_tick) begin
              pc <= '0;
              mc <= mc + DUR_W'(1);
            end else begin
              pc <= pc + PC_W'(1);
            end
            // Later assignments here override the counter and toggle updates above.
            if (play_end) begin
              pc   <= '0;
              mc   <= '0;
              hc   <= '0;
              tone <= 1'b0;
              if (GAP_MS != 0) begin
                state <= S_GAP;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end

        S_GAP: begin
          tone <= 1'b0;
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pc    <= '0;
            mc    <= '0;
          end else if (gap_end) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pc    <= '0;
            mc    <= '0;
          end else if (ms_tick) begin
            pc <= '0;
            mc <= mc + DUR_W'(1);
          end else begin
            pc <= pc + PC_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          tone  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// Testbench for tone_gen: two instances (no gap / 1 ms gap) at MS_DIV=10, driven by
// a table of notes, hand-written corner sequences and random notes against a waveform model.
module tb_tone_gen;

  localparam int M = 10;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]      start_v;
  logic [1:0]      stop_v;
  logic [1:0][7:0] hp_v;
  logic [1:0][7:0] dur_v;
  wire  [1:0]      tone_v;
  wire  [1:0]      busy_v;
  wire  [1:0]      done_v;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int gap_sel;
    int hp;
    int dur;
    int exp_busy;
    int exp_toggles;
    int exp_first_high;
    int exp_done_at;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  tone_gen #(.CLK_HZ(10_000), .CNT_W(8), .DUR_W(8), .GAP_MS(0)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .stop(stop_v[0]),
    .half_period(hp_v[0]), .dur_ms(dur_v[0]),
    .tone(tone_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  tone_gen #(.CLK_HZ(10_000), .CNT_W(8), .DUR_W(8), .GAP_MS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .stop(stop_v[1]),
    .half_period(hp_v[1]), .dur_ms(dur_v[1]),
    .tone(tone_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  // Expected {tone, busy, done} k cycles after the accepting edge of a fresh note.
  function automatic logic [2:0] refModel(input int hp, input int dur, input int gap, input int k);
    int play_len;
    int total;
    logic t;
    logic b;
    logic d;
    play_len = dur * M;
    total    = (dur + gap) * M;
    b = (k >= 1) && (k <= total);
    d = (k == total + 1);
    t = 1'b0;
    if (b && k <= play_len && hp != 0) t = (((k - 1) / hp) % 2) == 1;
    return {t, b, d};
  endfunction

  task automatic applyStimulus(input int idx, input logic st, input logic sp, input int hp, input int dur);
    start_v[idx] = st;
    stop_v[idx]  = sp;
    hp_v[idx]    = 8'(hp);
    dur_v[idx]   = 8'(dur);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic waitIdle(input int idx, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done_v[idx]) begin
        seen = 1;
        break;
      end
    end
    checkOutput({name, " done reached"}, seen, 1);
  endtask

  initial begin
    vecs[0] = '{0,   3,   2,   20,   6, 4,   21};
    vecs[1] = '{1,   0,   1,   20,   0, 0,   21};
    vecs[2] = '{0,   1,   1,   10,  10, 2,   11};
    vecs[3] = '{0,   5,   0,    0,   0, 0,    1};
    vecs[4] = '{1,   2,   0,   10,   0, 0,   11};
    vecs[5] = '{1,   2,   2,   30,  10, 3,   31};
    vecs[6] = '{0, 255,   1,   10,   0, 0,   11};
    vecs[7] = '{0,   4, 255, 2550, 638, 5, 2551};

    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1, 1'b0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("reset%0d tone", g), int'(tone_v[g]), 0);
      checkOutput($sformatf("reset%0d busy", g), int'(busy_v[g]), 0);
      checkOutput($sformatf("reset%0d done", g), int'(done_v[g]), 0);
    end

    // Table of whole notes: measure busy length, toggles, first high cycle, done timing.
    for (int v = 0; v < 8; v++) begin
      int g;
      int busy_cnt;
      int tog;
      int first;
      int done_at;
      int done_cnt;
      logic prev;
      g = vecs[v].gap_sel;
      busy_cnt = 0; tog = 0; first = 0; done_at = 0; done_cnt = 0; prev = 1'b0;
      applyStimulus(g, 1'b1, 1'b0, vecs[v].hp, vecs[v].dur);
      for (int k = 1; k <= 3000; k++) begin
        @(negedge clk);
        if (k == 1) applyStimulus(g, 1'b0, 1'b0, vecs[v].hp, vecs[v].dur);
        if (busy_v[g]) busy_cnt++;
        if (tone_v[g] != prev) tog++;
        if (tone_v[g] && first == 0) first = k;
        prev = tone_v[g];
        if (done_v[g]) begin
          done_cnt++;
          if (done_at == 0) done_at = k;
        end
        if (done_at != 0 && k > done_at) break;
      end
      checkOutput($sformatf("vec%0d busy cycles", v), busy_cnt, vecs[v].exp_busy);
      checkOutput($sformatf("vec%0d toggles", v), tog, vecs[v].exp_toggles);
      checkOutput($sformatf("vec%0d first high", v), first, vecs[v].exp_first_high);
      checkOutput($sformatf("vec%0d done at", v), done_at, vecs[v].exp_done_at);
      checkOutput($sformatf("vec%0d done pulses", v), done_cnt, 1);
    end

    // Back-to-back: a new start in the done cycle is accepted immediately.
    begin
      int seen;
      seen = 0;
      applyStimulus(0, 1'b1, 1'b0, 1, 1);
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (k == 1) applyStimulus(0, 1'b0, 1'b0, 1, 1);
        if (done_v[0]) begin
          seen = 1;
          checkOutput("b2b busy in done cycle", int'(busy_v[0]), 0);
          applyStimulus(0, 1'b1, 1'b0, 2, 1);
          break;
        end
      end
      checkOutput("b2b first done", seen, 1);
      @(negedge clk);
      checkOutput("b2b busy next cycle", int'(busy_v[0]), 1);
      applyStimulus(0, 1'b0, 1'b0, 2, 1);
      @(negedge clk);
      checkOutput("b2b tone k2", int'(tone_v[0]), 0);
      @(negedge clk);
      checkOutput("b2b tone k3", int'(tone_v[0]), 1);
      waitIdle(0, "b2b second note");
      @(negedge clk);
    end

    // Stop mid-note, with an ignored start (different hp) during the busy window.
    begin
      int highs;
      applyStimulus(0, 1'b1, 1'b0, 3, 3);
      @(negedge clk);
      applyStimulus(0, 1'b0, 1'b0, 3, 3);
      @(negedge clk);
      applyStimulus(0, 1'b1, 1'b0, 1, 3);
      @(negedge clk);
      applyStimulus(0, 1'b0, 1'b0, 1, 3);
      checkOutput("stop tone k3", int'(tone_v[0]), 0);
      @(negedge clk);
      checkOutput("stop tone k4", int'(tone_v[0]), 1);
      @(negedge clk);
      checkOutput("stop tone k5", int'(tone_v[0]), 1);
      checkOutput("stop busy k5", int'(busy_v[0]), 1);
      applyStimulus(0, 1'b0, 1'b1, 1, 3);
      @(negedge clk);
      applyStimulus(0, 1'b0, 1'b0, 1, 3);
      checkOutput("stop busy after", int'(busy_v[0]), 0);
      checkOutput("stop tone after", int'(tone_v[0]), 0);
      checkOutput("stop done after", int'(done_v[0]), 0);
      highs = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        highs += int'(done_v[0]) + int'(busy_v[0]);
      end
      checkOutput("stop no later done/busy", highs, 0);
    end

    // Simultaneous start and stop in IDLE does nothing.
    begin
      int highs;
      applyStimulus(1, 1'b1, 1'b1, 2, 1);
      @(negedge clk);
      applyStimulus(1, 1'b0, 1'b0, 2, 1);
      highs = 0;
      for (int k = 0; k < 25; k++) begin
        highs += int'(done_v[1]) + int'(busy_v[1]) + int'(tone_v[1]);
        @(negedge clk);
      end
      checkOutput("start+stop idle activity", highs, 0);
    end

    // Reset in the middle of a note.
    begin
      int highs;
      applyStimulus(1, 1'b1, 1'b0, 2, 3);
      @(negedge clk);
      applyStimulus(1, 1'b0, 1'b0, 2, 3);
      repeat (6) @(negedge clk);
      checkOutput("rst busy before", int'(busy_v[1]), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst tone", int'(tone_v[1]), 0);
      checkOutput("rst busy", int'(busy_v[1]), 0);
      checkOutput("rst done", int'(done_v[1]), 0);
      highs = 0;
      for (int k = 0; k < 45; k++) begin
        @(negedge clk);
        highs += int'(done_v[1]) + int'(busy_v[1]) + int'(tone_v[1]);
      end
      checkOutput("rst stays idle", highs, 0);
    end

    // Random notes compared cycle by cycle, with an ignored start injected while busy.
    for (int it = 0; it < 20; it++) begin
      int g;
      int hp;
      int dur;
      int total;
      int inj;
      logic [2:0] e;
      g     = int'($urandom_range(0, 1));
      hp    = int'($urandom_range(0, 6));
      dur   = int'($urandom_range(0, 4));
      total = (dur + g) * M;
      inj   = (total >= 2) ? int'($urandom_range(2, total)) : 0;
      applyStimulus(g, 1'b1, 1'b0, hp, dur);
      for (int k = 1; k <= total + 2; k++) begin
        @(negedge clk);
        e = refModel(hp, dur, g, k);
        checkOutput($sformatf("rand%0d k%0d tone", it, k), int'(tone_v[g]), int'(e[2]));
        checkOutput($sformatf("rand%0d k%0d busy", it, k), int'(busy_v[g]), int'(e[1]));
        checkOutput($sformatf("rand%0d k%0d done", it, k), int'(done_v[g]), int'(e[0]));
        if (k == inj) applyStimulus(g, 1'b1, 1'b0, int'($urandom_range(1, 7)), dur);
        else          applyStimulus(g, 1'b0, 1'b0, hp, dur);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
# tone_gen

Parametrised square-wave tone generator with per-note half-period, note duration in milliseconds, an optional silent articulation gap, and a start/busy/done handshake. It supersedes the fixed-frequency, enable-gated note clocks. A sequencer can now play a melody by issuing one note at a time through a single instance, with rests, aborts and a completion pulse.

## Interface
- CLK_HZ, 100_000_000, system clock frequency; MS_DIV = CLK_HZ/1000, must be ≥ 1
- CNT_W, 18, width of half_period and of the internal half-period counter
- DUR_W, 16, width of dur_ms
- GAP_MS, 0, silent gap in ms appended after every note; 0 disables the gap
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- stop  input  1  abort the current note; honoured in PLAY and GAP
- half_period  input  CNT_W  clk cycles per half period of tone; 0 = rest; latched on accepted start
- dur_ms  input  DUR_W  note length in ms; latched on accepted start
- tone  output  1  square-wave audio output
- busy  output  1  high from the cycle after an accepted start until done or abort
- done  output  1  one-cycle pulse when a note, including its gap, completes

## Operation
- States: IDLE, PLAY, GAP.
- Reset values: state IDLE; tone = 0, busy = 0, done = 0; all counters 0.
- IDLE:
  - start=1 and stop=0 → latch half_period/dur_ms, clear counters, tone=0.
  - Next state is PLAY if dur_ms≠0. If dur_ms=0, next state is GAP when GAP_MS≠0, otherwise done pulses next cycle and the state stays IDLE.
  - start and stop both high in IDLE → start ignored.
- PLAY:
  - Half-period counter hc counts 0..hp-1. At hc=hp-1, tone toggles and hc returns to 0.
  - hp=1 → tone toggles every cycle. hp=0 → tone held 0, hc held 0.
  - ms prescaler pc counts 0..MS_DIV-1. At pc=MS_DIV-1, ms counter mc increments.
  - Leave PLAY when mc reaches the latched dur_ms: go to GAP if GAP_MS≠0, else return to IDLE with done.
- GAP: tone forced 0; same prescaler counts GAP_MS ms; then IDLE with done.
- stop=1 in PLAY or GAP → next cycle IDLE, tone=0, busy=0, done stays 0.
- start while busy → ignored; latched values never change mid-note.
- Width rules:
  - pc is $clog2(MS_DIV) bits, minimum 1.
  - mc is DUR_W bits; the maximum dur_ms is played in full, with no wrap.
  - hc compare uses CNT_W bits.

## Timing
- start accepted at edge T:
  - busy=1 and state PLAY from T+1.
  - The first tone edge is at T+hp, so the first high half starts hp cycles after PLAY entry.
- PLAY lasts exactly dur_ms·MS_DIV cycles. GAP lasts exactly GAP_MS·MS_DIV cycles.
- done is high for exactly the one cycle in which state has returned to IDLE; busy=0 in that same cycle.
- Back-to-back: start may be asserted in the done cycle and is accepted, giving zero idle cycles between notes.
- tone is registered, with no combinational path from inputs to outputs.
- rst high at any edge overrides start and stop: all outputs are 0 from the next cycle, and a pending done is suppressed.

## Test plan
Bench uses CLK_HZ=10_000 (MS_DIV=10), CNT_W=8, DUR_W=8.
- GAP_MS=0, start with hp=3, dur_ms=2:
  - busy high for 20 cycles; tone toggles every 3 cycles (6 toggles, first at T+3).
  - done pulses once at T+21; tone 0 after.
- GAP_MS=1, hp=0, dur_ms=1:
  - tone stays 0 for all 20 busy cycles; done after PLAY(10)+GAP(10).
- hp=1, dur_ms=1, GAP_MS=0:
  - tone alternates every cycle for 10 cycles.
  - start re-asserted in the done cycle → busy re-rises next cycle with no gap.
- stop asserted 5 cycles into a dur_ms=3 note:
  - next cycle busy=0, tone=0, no done pulse.
  - start during that busy window was ignored, and latched hp is unchanged.
- dur_ms=0 with GAP_MS=0 → done one cycle after start, tone never toggles.
- Simultaneous start+stop in IDLE → nothing happens.
- rst mid-PLAY → tone/busy/done 0 next cycle and remain idle until a new start.
